// File: rtl/operand_fetch_pkg.sv
// operand_fetch_pkg: shared widths, ID/EX bundle and forwarding select encoding
package operand_fetch_pkg;
  localparam int OPF_XLEN = 32;
  localparam int OPF_AW = 5;
  typedef enum logic [1:0] {FWD_RF, FWD_MEM, FWD_WB, FWD_ZERO} fwd_sel_e;
  typedef struct packed {
    logic                valid;
    logic [OPF_XLEN-1:0] rs1_data;
    logic [OPF_XLEN-1:0] rs2_data;
    logic [OPF_AW-1:0]   rd_addr;
    logic                rd_wren;
    logic                is_load;
    logic [OPF_XLEN-1:0] pc;
  } idex_t;
endpackage

// File: rtl/operand_fetch_fwd_mux.sv
// fwd_mux: resolves one source operand from x0, the MEM writer, the WB writer or the regfile
module fwd_mux import operand_fetch_pkg::*; #(
  parameter int XLEN = OPF_XLEN,
  parameter int AW = OPF_AW
) (
  input  logic [AW-1:0]   addr,
  input  logic [XLEN-1:0] rf_data,
  input  logic [AW-1:0]   mem_addr,
  input  logic            mem_wren,
  input  logic            mem_is_load,
  input  logic [XLEN-1:0] mem_data,
  input  logic [AW-1:0]   wb_addr,
  input  logic            wb_wren,
  input  logic [XLEN-1:0] wb_data,
  output fwd_sel_e        sel,
  output logic [XLEN-1:0] data
);
  // youngest ALU producer wins; load data in MEM is not ready yet
  always_comb begin
    sel = addr == '0 ? FWD_ZERO :
          (mem_wren && !mem_is_load && mem_addr == addr) ? FWD_MEM :
          (wb_wren && wb_addr == addr) ? FWD_WB : FWD_RF;
    data = sel == FWD_MEM ? mem_data : sel == FWD_WB ? wb_data : sel == FWD_RF ? rf_data : '0;
  end
endmodule

// File: rtl/operand_fetch.sv
// operand_fetch: operand forwarding, hazard stall and ID/EX register; OPFETCH_PERF_EN builds the stall counter
module operand_fetch import operand_fetch_pkg::*; #(
  parameter int XLEN = OPF_XLEN,
  parameter int AW = OPF_AW
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            id_valid_i,
  input  logic [AW-1:0]   id_rs1_addr_i,
  input  logic [AW-1:0]   id_rs2_addr_i,
  input  logic            id_rs1_use_i,
  input  logic            id_rs2_use_i,
  output logic [AW-1:0]   rs1_addr_o,
  output logic [AW-1:0]   rs2_addr_o,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic [AW-1:0]   id_rd_addr_i,
  input  logic            id_rd_wren_i,
  input  logic            id_is_load_i,
  input  logic [XLEN-1:0] id_pc_i,
  input  logic [AW-1:0]   mem_rd_addr_i,
  input  logic            mem_rd_wren_i,
  input  logic            mem_is_load_i,
  input  logic [XLEN-1:0] mem_rd_data_i,
  input  logic [AW-1:0]   wb_rd_addr_i,
  input  logic            wb_rd_wren_i,
  input  logic [XLEN-1:0] wb_rd_data_i,
  input  logic            flush_i,
  input  logic            ex_hold_i,
  output logic            stall_o,
  output logic            ex_valid_o,
  output logic [XLEN-1:0] ex_rs1_data_o,
  output logic [XLEN-1:0] ex_rs2_data_o,
  output logic [AW-1:0]   ex_rd_addr_o,
  output logic            ex_rd_wren_o,
  output logic            ex_is_load_o,
  output logic [XLEN-1:0] ex_pc_o,
  output logic [31:0]     perf_stall_cnt_o
);
  idex_t           ex_r;
  fwd_sel_e        sel1, sel2;
  logic [XLEN-1:0] op1, op2;
  logic            hz_ex, hz_mem, hazard;
  assign rs1_addr_o = id_rs1_addr_i;
  assign rs2_addr_o = id_rs2_addr_i;
  fwd_mux #(.XLEN(XLEN), .AW(AW)) u_fwd_rs1 (
    .addr(id_rs1_addr_i), .rf_data(rs1_data_i),
    .mem_addr(mem_rd_addr_i), .mem_wren(mem_rd_wren_i), .mem_is_load(mem_is_load_i), .mem_data(mem_rd_data_i),
    .wb_addr(wb_rd_addr_i), .wb_wren(wb_rd_wren_i), .wb_data(wb_rd_data_i),
    .sel(sel1), .data(op1)
  );
  fwd_mux #(.XLEN(XLEN), .AW(AW)) u_fwd_rs2 (
    .addr(id_rs2_addr_i), .rf_data(rs2_data_i),
    .mem_addr(mem_rd_addr_i), .mem_wren(mem_rd_wren_i), .mem_is_load(mem_is_load_i), .mem_data(mem_rd_data_i),
    .wb_addr(wb_rd_addr_i), .wb_wren(wb_rd_wren_i), .wb_data(wb_rd_data_i),
    .sel(sel2), .data(op2)
  );
  // used non-x0 sources against the EX writer and a load in MEM; reset masks the EX side
  always_comb begin
    hz_ex = !rst_i && ex_r.valid && ex_r.rd_wren &&
            ((id_rs1_use_i && sel1 != FWD_ZERO && id_rs1_addr_i == ex_r.rd_addr) ||
             (id_rs2_use_i && sel2 != FWD_ZERO && id_rs2_addr_i == ex_r.rd_addr));
    hz_mem = mem_rd_wren_i && mem_is_load_i &&
             ((id_rs1_use_i && sel1 != FWD_ZERO && id_rs1_addr_i == mem_rd_addr_i) ||
              (id_rs2_use_i && sel2 != FWD_ZERO && id_rs2_addr_i == mem_rd_addr_i));
    hazard = id_valid_i && (hz_ex || hz_mem);
    stall_o = !flush_i && (ex_hold_i || hazard);
  end
  // ID/EX register: flush and hazard insert a bubble, hold freezes, otherwise capture decode
  always_ff @(posedge clk_i) begin
    if (rst_i) ex_r <= '0;
    else if (flush_i || (!ex_hold_i && hazard)) begin
      ex_r.valid <= 1'b0;
      ex_r.rd_wren <= 1'b0;
      ex_r.is_load <= 1'b0;
    end else if (!ex_hold_i) ex_r <= '{valid: id_valid_i, rs1_data: op1, rs2_data: op2, rd_addr: id_rd_addr_i,
                                       rd_wren: id_valid_i && id_rd_wren_i, is_load: id_valid_i && id_is_load_i,
                                       pc: id_pc_i};
  end
  assign ex_valid_o = ex_r.valid;
  assign ex_rs1_data_o = ex_r.rs1_data;
  assign ex_rs2_data_o = ex_r.rs2_data;
  assign ex_rd_addr_o = ex_r.rd_addr;
  assign ex_rd_wren_o = ex_r.rd_wren;
  assign ex_is_load_o = ex_r.is_load;
  assign ex_pc_o = ex_r.pc;
`ifdef OPFETCH_PERF_EN
  logic [31:0] perf_cnt;
  // counts hazard bubbles only, saturating at all ones
  always_ff @(posedge clk_i) begin
    if (rst_i) perf_cnt <= '0;
    else if (!flush_i && !ex_hold_i && hazard && perf_cnt != '1) perf_cnt <= perf_cnt + 32'd1;
  end
  assign perf_stall_cnt_o = perf_cnt;
`else
  assign perf_stall_cnt_o = '0;
`endif
endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: architectural golden model with slot-distance stall rule checks operand_fetch
module tb_operand_fetch;
`ifdef OPFETCH_PERF_EN
  localparam bit PERF_EN = 1'b1;
`else
  localparam bit PERF_EN = 1'b0;
`endif
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_i, id_valid_i, id_rs1_use_i, id_rs2_use_i, id_rd_wren_i, id_is_load_i;
  logic [4:0] id_rs1_addr_i, id_rs2_addr_i, rs1_addr_o, rs2_addr_o, id_rd_addr_i, mem_rd_addr_i, wb_rd_addr_i, ex_rd_addr_o;
  logic [31:0] rs1_data_i, rs2_data_i, id_pc_i, mem_rd_data_i, wb_rd_data_i;
  logic mem_rd_wren_i, mem_is_load_i, wb_rd_wren_i, flush_i, ex_hold_i, stall_o, ex_valid_o, ex_rd_wren_o, ex_is_load_o;
  logic [31:0] ex_rs1_data_o, ex_rs2_data_o, ex_pc_o, perf_stall_cnt_o;
  operand_fetch dut (
    .clk_i(clk), .rst_i(rst_i), .id_valid_i(id_valid_i),
    .id_rs1_addr_i(id_rs1_addr_i), .id_rs2_addr_i(id_rs2_addr_i),
    .id_rs1_use_i(id_rs1_use_i), .id_rs2_use_i(id_rs2_use_i),
    .rs1_addr_o(rs1_addr_o), .rs2_addr_o(rs2_addr_o),
    .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
    .id_rd_addr_i(id_rd_addr_i), .id_rd_wren_i(id_rd_wren_i), .id_is_load_i(id_is_load_i), .id_pc_i(id_pc_i),
    .mem_rd_addr_i(mem_rd_addr_i), .mem_rd_wren_i(mem_rd_wren_i), .mem_is_load_i(mem_is_load_i), .mem_rd_data_i(mem_rd_data_i),
    .wb_rd_addr_i(wb_rd_addr_i), .wb_rd_wren_i(wb_rd_wren_i), .wb_rd_data_i(wb_rd_data_i),
    .flush_i(flush_i), .ex_hold_i(ex_hold_i), .stall_o(stall_o),
    .ex_valid_o(ex_valid_o), .ex_rs1_data_o(ex_rs1_data_o), .ex_rs2_data_o(ex_rs2_data_o),
    .ex_rd_addr_o(ex_rd_addr_o), .ex_rd_wren_o(ex_rd_wren_o), .ex_is_load_o(ex_is_load_o),
    .ex_pc_o(ex_pc_o), .perf_stall_cnt_o(perf_stall_cnt_o)
  );
  typedef struct packed {
    logic v; logic [4:0] rs1; logic [4:0] rs2; logic u1; logic u2; logic [4:0] rd; logic w; logic ld; logic [31:0] pc;
  } instr_t;
  typedef struct packed {
    logic v; logic [4:0] rd; logic w; logic ld; logic u1; logic u2;
    logic [31:0] o1; logic [31:0] o2; logic [31:0] res; logic [31:0] pc;
  } stage_t;
  instr_t q[$];
  stage_t ex_m, mem_m, wb_m;
  logic [31:0] gold [32];
  logic [31:0] rf [32];
  int last_slot [32];
  bit last_ld [32];
  int slot, checks, failures, stall_n;
  logic [31:0] exp_perf, pc_n, p0;
  logic last_stall;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic instr_t mk(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2, input logic u2,
                                input logic [4:0] rd, input logic w, input logic ld);
    instr_t i;
    i = '{v: 1'b1, rs1: rs1, rs2: rs2, u1: u1, u2: u2, rd: rd, w: w, ld: ld, pc: pc_n};
    pc_n += 32'd4;
    return i;
  endfunction
  function automatic instr_t rnd_instr();
    instr_t i;
    i.v = $urandom_range(9) != 0;
    i.rs1 = 5'($urandom_range(7));
    i.rs2 = 5'($urandom_range(7));
    i.u1 = $urandom_range(3) != 0;
    i.u2 = $urandom_range(3) != 0;
    i.rd = 5'($urandom_range(7));
    i.ld = $urandom_range(2) == 0;
    i.w = i.ld || $urandom_range(5) != 0;
    i.pc = pc_n;
    pc_n += 32'd4;
    return i;
  endfunction
  task automatic step(input bit f, input bit h, input bit r);
    instr_t ins;
    int req;
    bit hz;
    @(negedge clk);
    ins = '0;
    if (q.size() != 0) ins = q[0];
    rst_i = r; flush_i = f; ex_hold_i = h;
    id_valid_i = ins.v; id_rs1_addr_i = ins.rs1; id_rs2_addr_i = ins.rs2;
    id_rs1_use_i = ins.u1; id_rs2_use_i = ins.u2;
    id_rd_addr_i = ins.rd; id_rd_wren_i = ins.w; id_is_load_i = ins.ld; id_pc_i = ins.pc;
    rs1_data_i = rf[ins.rs1]; rs2_data_i = rf[ins.rs2];
    mem_rd_addr_i = mem_m.rd; mem_rd_wren_i = mem_m.v && mem_m.w; mem_is_load_i = mem_m.v && mem_m.ld;
    mem_rd_data_i = mem_m.ld ? $urandom() : mem_m.res;
    wb_rd_addr_i = wb_m.rd; wb_rd_wren_i = wb_m.v && wb_m.w; wb_rd_data_i = wb_m.res;
    req = 0;
    if (ins.u1 && ins.rs1 != 0) req = last_slot[ins.rs1] + (last_ld[ins.rs1] ? 3 : 2);
    if (ins.u2 && ins.rs2 != 0 && last_slot[ins.rs2] + (last_ld[ins.rs2] ? 3 : 2) > req)
      req = last_slot[ins.rs2] + (last_ld[ins.rs2] ? 3 : 2);
    hz = ins.v && slot < req;
    #1;
    last_stall = stall_o;
    if (stall_o) stall_n++;
    check("rs1_addr_pass", 32'(rs1_addr_o), 32'(ins.rs1));
    if (!r) check("stall", 32'(stall_o), f ? 32'd0 : h ? 32'd1 : 32'(hz));
    @(posedge clk);
    if (r) begin
      ex_m = '0; mem_m = '0; wb_m = '0;
      gold = rf; gold[0] = '0;
      for (int i = 0; i < 32; i++) last_slot[i] = -100;
      slot = 0; exp_perf = '0;
    end else if (!h) begin
      if (wb_m.v && wb_m.w && wb_m.rd != 0) rf[wb_m.rd] = wb_m.res;
      wb_m = mem_m;
      mem_m = ex_m;
      ex_m = '0;
      if (f) begin
        if (q.size() != 0) void'(q.pop_front());
      end else if (hz) exp_perf++;
      else begin
        if (ins.v) begin
          ex_m.v = 1'b1; ex_m.rd = ins.rd; ex_m.w = ins.w; ex_m.ld = ins.ld; ex_m.pc = ins.pc;
          ex_m.u1 = ins.u1; ex_m.u2 = ins.u2; ex_m.o1 = gold[ins.rs1]; ex_m.o2 = gold[ins.rs2];
          ex_m.res = ins.ld ? ins.pc * 32'h9e3779b1 : ins.pc ^ ((ins.u1 ? ex_m.o1 : 32'd0) + (ins.u2 ? ex_m.o2 : 32'd0));
          if (ins.w && ins.rd != 0) begin
            gold[ins.rd] = ex_m.res;
            last_slot[ins.rd] = slot;
            last_ld[ins.rd] = ins.ld;
          end
        end
        if (q.size() != 0) void'(q.pop_front());
      end
      slot++;
    end
    #1;
    check("ex_valid", 32'(ex_valid_o), 32'(ex_m.v));
    check("ex_rd_wren", 32'(ex_rd_wren_o), 32'(ex_m.v && ex_m.w));
    check("ex_is_load", 32'(ex_is_load_o), 32'(ex_m.v && ex_m.ld));
    if (r) begin
      check("rst_rs1", ex_rs1_data_o, 32'd0);
      check("rst_rs2", ex_rs2_data_o, 32'd0);
      check("rst_rd", 32'(ex_rd_addr_o), 32'd0);
      check("rst_pc", ex_pc_o, 32'd0);
    end else if (ex_m.v) begin
      check("ex_rd_addr", 32'(ex_rd_addr_o), 32'(ex_m.rd));
      check("ex_pc", ex_pc_o, ex_m.pc);
      if (ex_m.u1) check("ex_rs1_data", ex_rs1_data_o, ex_m.o1);
      if (ex_m.u2) check("ex_rs2_data", ex_rs2_data_o, ex_m.o2);
    end
    check("perf", perf_stall_cnt_o, PERF_EN ? exp_perf : 32'd0);
  endtask
  initial begin
    checks = 0; failures = 0; stall_n = 0; slot = 0; pc_n = 32'h1000; exp_perf = '0;
    for (int i = 0; i < 32; i++) begin
      rf[i] = '0; gold[i] = '0; last_slot[i] = -100; last_ld[i] = 1'b0;
    end
    rf[0] = 32'hdeadbeef;
    ex_m = '0; mem_m = '0; wb_m = '0;
    step(0, 0, 1);
    step(0, 0, 1);
    check("reset_perf", perf_stall_cnt_o, 32'd0);
    wb_m = '0; wb_m.v = 1'b1; wb_m.rd = 5'd5; wb_m.w = 1'b1; wb_m.res = 32'h13579bdf;
    gold[5] = 32'h13579bdf;
    q.push_back(mk(5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0));
    step(0, 0, 0);
    check("wb_fwd_data", ex_rs1_data_o, 32'h13579bdf);
    check("wb_fwd_stall", 32'(last_stall), 32'd0);
    mem_m = '0; mem_m.v = 1'b1; mem_m.rd = 5'd5; mem_m.w = 1'b1; mem_m.res = 32'h1;
    wb_m = '0; wb_m.v = 1'b1; wb_m.rd = 5'd5; wb_m.w = 1'b1; wb_m.res = 32'h2;
    gold[5] = 32'h1;
    q.push_back(mk(5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0));
    step(0, 0, 0);
    check("mem_over_wb", ex_rs1_data_o, 32'h1);
    q.push_back(mk(5'd1, 1'b0, 5'd2, 1'b0, 5'd0, 1'b1, 1'b0));
    q.push_back(mk(5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0));
    step(0, 0, 0);
    step(0, 0, 0);
    check("x0_no_stall", 32'(last_stall), 32'd0);
    check("x0_operand", ex_rs1_data_o, 32'd0);
    stall_n = 0; p0 = perf_stall_cnt_o;
    q.push_back(mk(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1));
    q.push_back(mk(5'd0, 1'b0, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0));
    repeat (4) step(0, 0, 0);
    check("load_use_stalls", 32'(stall_n), 32'd2);
    check("load_use_issue", 32'(ex_valid_o), 32'd1);
    check("load_use_perf", perf_stall_cnt_o - p0, PERF_EN ? 32'd2 : 32'd0);
    q.push_back(mk(5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0));
    q.push_back(mk(5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0));
    step(0, 0, 0);
    step(1, 0, 0);
    check("flush_stall", 32'(last_stall), 32'd0);
    check("flush_bubble", 32'(ex_valid_o), 32'd0);
    q.push_back(mk(5'd1, 1'b1, 5'd2, 1'b1, 5'd4, 1'b1, 1'b0));
    step(0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      step(0, 1, 0);
      check("hold_stall", 32'(last_stall), 32'd1);
      check("hold_valid", 32'(ex_valid_o), 32'd1);
    end
    q.push_back(mk(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1));
    q.push_back(mk(5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0));
    step(0, 0, 0);
    step(0, 0, 0);
    check("pre_rst_stall", 32'(last_stall), 32'd1);
    step(0, 0, 1);
    check("rst_mid_valid", 32'(ex_valid_o), 32'd0);
    check("rst_mid_perf", perf_stall_cnt_o, 32'd0);
    step(0, 0, 0);
    check("post_rst_stall", 32'(last_stall), 32'd0);
    for (int n = 0; n < 800; n++) begin
      bit f, h, r;
      while (q.size() < 4) q.push_back(rnd_instr());
      r = $urandom_range(199) == 0;
      f = $urandom_range(24) == 0;
      h = !f && $urandom_range(11) == 0;
      step(f, h, r);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
